// File: rtl/dbus_pair_arbiter.sv
// Serialises the two Memory-stage dbus slots onto one downstream port, slot 1 first,
// and answers both slots together in a single RESP cycle so the pair retires atomically.
package dbus_pair_arbiter_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

endpackage

module dbus_pair_arbiter
   import dbus_pair_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  s1_req,
   output dbus_resp_t s1_resp,
   input  dbus_req_t  s2_req,
   output dbus_resp_t s2_resp,
   output dbus_req_t  m_req,
   input  dbus_resp_t m_resp,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, SERV1, SERV2, RESP} state_t;

   state_t      state;
   state_t      state_next;
   dbus_req_t   req1;
   dbus_req_t   req2;
   logic        served1;
   logic        served2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [15:0] wd;
   logic [16:0] wd_inc;
   logic        timeout_q;
   logic        in_serv;
   logic        unused_addr_ok;

   // addr_ok carries no information here: a slot is finished only by data_ok
   assign unused_addr_ok = m_resp.addr_ok;

   assign in_serv = (state == SERV1) || (state == SERV2);
   assign wd_inc  = {1'b0, wd} + 17'd1;
   assign busy    = (state != IDLE);
   assign timeout = timeout_q;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (s1_req.valid)      state_next = SERV1;
            else if (s2_req.valid) state_next = SERV2;
         end
         SERV1: if (m_resp.data_ok) state_next = served2 ? SERV2 : RESP;
         SERV2: if (m_resp.data_ok) state_next = RESP;
         RESP:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      m_req   = '0;
      s1_resp = '0;
      s2_resp = '0;
      case (state)
         SERV1: begin
            m_req       = req1;
            m_req.valid = 1'b1;
         end
         SERV2: begin
            m_req       = req2;
            m_req.valid = 1'b1;
         end
         RESP: begin
            s1_resp.addr_ok = served1;
            s1_resp.data_ok = served1;
            s1_resp.data    = rdata1;
            s2_resp.addr_ok = served2;
            s2_resp.data_ok = served2;
            s2_resp.data    = rdata2;
         end
         default: ;
      endcase
   end

   // Requests are snapshotted in IDLE so later upstream changes cannot disturb an access
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         req1    <= '0;
         req2    <= '0;
         served1 <= 1'b0;
         served2 <= 1'b0;
         rdata1  <= '0;
         rdata2  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE) begin
            req1    <= s1_req;
            req2    <= s2_req;
            served1 <= s1_req.valid;
            served2 <= s2_req.valid;
         end
         if ((state == SERV1) && m_resp.data_ok) rdata1 <= m_resp.data;
         if ((state == SERV2) && m_resp.data_ok) rdata2 <= m_resp.data;
      end
   end

   // wd sits at zero outside SERV states, which doubles as the clear on SERV entry
   always_ff @(posedge clk) begin
      if (reset) begin
         wd        <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (!in_serv || m_resp.data_ok) wd <= '0;
         else if (wd != 16'hFFFF)        wd <= wd_inc[15:0];
         if ((TIMEOUT_CYCLES != 0) && in_serv && !m_resp.data_ok &&
             (wd_inc == TIMEOUT_CYCLES[16:0]))
            timeout_q <= 1'b1;
      end
   end

endmodule
